dmem_arbiter: RTL and testbench

- Shares the single data-memory port (12-bit address, 32-bit word, synchronous read) between two requesters.
- Port 0 is the processor load/store path. Port 1 is the loader/debug path, which fills or inspects dmem.
- Arbitration is round-robin with a burst cap. Read data is tagged and returned to the requester that issued it.
- Sits between the processor/loader and the dmem instance. It runs on the dmem clock domain.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rd_return_pipe.sv | 47 ++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and state encoding for the dmem arbiter
package dmem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int DEF_BURST_MAX = 4;
  localparam int DEF_READ_LAT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rd_return_pipe.sv
// rtl/rd_return_pipe.sv - tags each accepted read with its port and times its return
module rd_return_pipe
  import dmem_arb_pkg::*;
#(
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_push,
  input  logic i_id,
  output logic o_rvalid0,
  output logic o_rvalid1,
  output logic o_busy
);

  logic [READ_LAT-1:0] r_valid;
  logic [READ_LAT-1:0] r_id;

  generate
    if (READ_LAT == 1) begin : g_single
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_valid <= '0;
          r_id    <= '0;
        end else begin
          r_valid <= i_push;
          r_id    <= i_id;
        end
      end
    end else begin : g_multi
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_valid <= '0;
          r_id    <= '0;
        end else begin
          r_valid <= {r_valid[READ_LAT-2:0], i_push};
          r_id    <= {r_id[READ_LAT-2:0], i_id};
        end
      end
    end
  endgenerate

  assign o_rvalid0 = r_valid[READ_LAT-1] & (r_id[READ_LAT-1] == PORT_CPU);
  assign o_rvalid1 = r_valid[READ_LAT-1] & (r_id[READ_LAT-1] == PORT_LDR);
  assign o_busy    = |r_valid;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin, burst-capped arbiter sharing one dmem port between CPU and loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, w_last_nxt;
  logic             w_gnt, w_win, w_gnt_ok, w_win_we;
  logic             w_own, w_own_req, w_oth_req;
  logic             w_rd_push, w_pipe_busy;

  assign w_own     = (r_state == OWN1);
  assign w_own_req = w_own ? req1 : req0;
  assign w_oth_req = w_own ? req0 : req1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= PORT_LDR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_gnt       = 1'b0;
    w_win       = r_last;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_gnt     = 1'b1;
          w_win     = (req0 && req1) ? ~r_last : req1;
          w_cnt_nxt = CNT_ONE;
        end
      end
      default: begin
        // Owner keeps the port unless the other side is waiting and the cap is reached.
        if (w_own_req && (!w_oth_req || (r_cnt < CNT_MAX))) begin
          w_gnt     = 1'b1;
          w_win     = w_own;
          w_cnt_nxt = (r_cnt < CNT_MAX) ? r_cnt + CNT_ONE : r_cnt;
        end else if (w_oth_req) begin
          w_gnt     = 1'b1;
          w_win     = ~w_own;
          w_cnt_nxt = CNT_ONE;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
    endcase
    if (w_gnt) begin
      w_last_nxt  = w_win;
      w_state_nxt = w_win ? OWN1 : OWN0;
    end
  end

  assign w_gnt_ok  = w_gnt & ~reset;
  assign w_win_we  = w_win ? we1 : we0;
  assign gnt0      = w_gnt_ok & (w_win == PORT_CPU);
  assign gnt1      = w_gnt_ok & (w_win == PORT_LDR);
  assign mem_wren  = w_gnt_ok & w_win_we;
  assign mem_addr  = w_gnt_ok ? (w_win ? addr1 : addr0) : '0;
  assign mem_wdata = w_gnt_ok ? (w_win ? wdata1 : wdata0) : '0;
  assign w_rd_push = w_gnt_ok & ~w_win_we;
  assign rdata     = mem_q;
  assign busy      = w_gnt_ok | w_pipe_busy;

  rd_return_pipe #(
    .READ_LAT(READ_LAT)
  ) u_rd_pipe (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_push   (w_rd_push),
    .i_id     (w_win),
    .o_rvalid0(rvalid0),
    .o_rvalid1(rvalid1),
    .o_busy   (w_pipe_busy)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a write-first dmem model
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy;
  logic [31:0] rdata, mem_wdata;
  logic [11:0] mem_addr;
  logic [31:0] mem_q = '0;
  logic [31:0] mem [0:4095];

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
      mem_q         <= mem_wdata;
    end else begin
      mem_q <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && (rvalid0 || rvalid1)) begin
      chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
      if (sb_q.size() == 0) begin
        chk("rvalid_spurious", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rvalid_port", 32'(rvalid1), 32'(e.port));
        chk("rdata", rdata, e.data);
      end
    end
  end

  task automatic drv0(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic exp_rd(input logic p, input logic [31:0] d);
    sb_q.push_back('{p, d});
  endtask

  task automatic tick(input logic eg0, input logic eg1, input logic eb, input string nm);
    logic        ew;
    logic [11:0] ea;
    @(negedge clock);
    ew = eg0 ? we0 : (eg1 ? we1 : 1'b0);
    ea = eg0 ? addr0 : (eg1 ? addr1 : 12'd0);
    chk({nm, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, eg1, eg0});
    chk({nm, "_wren"}, 32'(mem_wren), 32'(ew));
    chk({nm, "_addr"}, 32'(mem_addr), 32'(ea));
    chk({nm, "_busy"}, 32'(busy), 32'(eb));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #1 reset = 1'b1;
    drv0(1'b1, 1'b0, 12'h005, 32'd0);
    drv1(1'b1, 1'b0, 12'h006, 32'd0);
    tick(1'b0, 1'b0, 1'b0, "rst_hold");
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    reset = 1'b0;
    drv0(1'b0, 1'b0, 12'h000, 32'd0);
    drv1(1'b0, 1'b0, 12'h000, 32'd0);
    tick(1'b0, 1'b0, 1'b0, "idle");

    drv0(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    tick(1'b1, 1'b0, 1'b1, "s0_wr");
    drv0(1'b1, 1'b0, 12'h010, 32'd0);
    exp_rd(1'b0, 32'hDEADBEEF);
    tick(1'b1, 1'b0, 1'b1, "s0_rd");
    drv0(1'b0, 1'b0, 12'h000, 32'd0);
    tick(1'b0, 1'b0, 1'b1, "s0_ret");
    tick(1'b0, 1'b0, 1'b0, "s0_done");

    drv1(1'b1, 1'b1, 12'h001, 32'h11);
    tick(1'b0, 1'b1, 1'b1, "ld1");
    drv1(1'b1, 1'b1, 12'h002, 32'h22);
    tick(1'b0, 1'b1, 1'b1, "ld2");
    drv1(1'b0, 1'b0, 12'h000, 32'd0);
    tick(1'b0, 1'b0, 1'b0, "ld_done");

    drv0(1'b1, 1'b0, 12'h001, 32'd0);
    exp_rd(1'b0, 32'h11);
    tick(1'b1, 1'b0, 1'b1, "tag0");
    drv0(1'b0, 1'b0, 12'h000, 32'd0);
    drv1(1'b1, 1'b0, 12'h002, 32'd0);
    exp_rd(1'b1, 32'h22);
    tick(1'b0, 1'b1, 1'b1, "tag1");
    drv1(1'b0, 1'b0, 12'h000, 32'd0);
    tick(1'b0, 1'b0, 1'b1, "tag_ret");
    tick(1'b0, 1'b0, 1'b0, "tag_done");

    drv1(1'b1, 1'b1, 12'h003, 32'h33);
    tick(1'b0, 1'b1, 1'b1, "pre_rst");
    drv0(1'b1, 1'b1, 12'h100, 32'hA);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, "mid_rst");
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic g;
      g = (i >= 4) && (i < 8);
      tick(!g, g, 1'b1, $sformatf("burst%0d", i));
    end

    drv0(1'b0, 1'b0, 12'h000, 32'd0);
    drv1(1'b1, 1'b0, 12'h002, 32'd0);
    for (int i = 0; i < 10; i++) begin
      exp_rd(1'b1, 32'h22);
      tick(1'b0, 1'b1, 1'b1, $sformatf("solo1_%0d", i));
    end
    drv0(1'b1, 1'b1, 12'h101, 32'hC);
    tick(1'b1, 1'b0, 1'b1, "cap_sat");
    drv0(1'b0, 1'b0, 12'h000, 32'd0);
    drv1(1'b0, 1'b0, 12'h000, 32'd0);
    tick(1'b0, 1'b0, 1'b0, "solo_done");

    drv0(1'b1, 1'b0, 12'h001, 32'd0);
    tick(1'b1, 1'b0, 1'b1, "rif_rd");
    drv0(1'b0, 1'b0, 12'h000, 32'd0);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, "rif_rst");
    chk("rif_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, "rif_after");
    tick(1'b0, 1'b0, 1'b0, "rif_after2");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
